// File: rtl/upd1771c_cmd_tx_if.sv
// Host command / chip PA-port bundle for the uPD1771C command transmitter.
// slave = transmitter side, master = host/chip side that drives the inputs.
interface upd1771c_cmd_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic          CKEN;
    logic          PHI2P;
    logic [7:0]    WR_DATA;
    logic          WR_VALID;
    logic          WR_READY;
    logic [7:0]    PA_O;
    logic          PA_OE;
    logic          WRB;
    logic          ACK_I;
    logic          BUSY;
    logic          TIMEOUT;
    logic          TO_CLR;
    logic [LW-1:0] LEVEL;

    modport slave (
        input  CKEN, PHI2P, WR_DATA, WR_VALID, ACK_I, TO_CLR,
        output WR_READY, PA_O, PA_OE, WRB, BUSY, TIMEOUT, LEVEL
    );

    modport master (
        output CKEN, PHI2P, WR_DATA, WR_VALID, ACK_I, TO_CLR,
        input  WR_READY, PA_O, PA_OE, WRB, BUSY, TIMEOUT, LEVEL
    );
endinterface

// File: rtl/upd1771c_cmd_tx.sv
// Buffers host command bytes and strobes them onto the uPD1771C PA port, PHI2-aligned.
// WRB falls on the first CKEN&PHI2P after a pop; WR_READY drops only when the FIFO is full.
module upd1771c_cmd_tx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYC    = 8,
    parameter int GAP_CYC     = 72,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic CLK,
    input  logic RESB,
    upd1771c_cmd_tx_if.slave bus
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int LW   = AW + 1;
    localparam int MAX1 = (GAP_CYC > ACK_TIMEOUT) ? GAP_CYC : ACK_TIMEOUT;
    localparam int MAXC = (MAX1 > HOLD_CYC) ? MAX1 : HOLD_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_DRIVE, S_ACKW, S_GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [7:0]    shreg;
    logic [7:0]    pa_q;
    logic          oe_q;
    logic          wrb_q;
    logic          timeout_q;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;

    logic push;
    logic pop;
    logic to_set;

    assign bus.WR_READY = (count != LW'(FIFO_DEPTH));
    assign push   = bus.WR_VALID & bus.WR_READY;
    // The head leaves the FIFO on the same edge the FSM leaves IDLE.
    assign pop    = bus.CKEN & (state == S_IDLE) & (count != '0);
    assign to_set = bus.CKEN & (state == S_ACKW) & ~bus.ACK_I
                  & (cnt == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= bus.WR_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            state     <= S_IDLE;
            cnt       <= '0;
            shreg     <= 8'h00;
            pa_q      <= 8'h00;
            oe_q      <= 1'b0;
            wrb_q     <= 1'b1;
            timeout_q <= 1'b0;
        end else begin
            // A same-cycle clear wins over a new timeout.
            if (bus.TO_CLR) begin
                timeout_q <= 1'b0;
            end else if (to_set) begin
                timeout_q <= 1'b1;
            end

            if (bus.CKEN) begin
                case (state)
                    S_IDLE: begin
                        if (count != '0) begin
                            shreg <= mem[rd_ptr];
                            state <= S_ALIGN;
                        end
                    end
                    S_ALIGN: begin
                        if (bus.PHI2P) begin
                            pa_q  <= shreg;
                            oe_q  <= 1'b1;
                            wrb_q <= 1'b0;
                            cnt   <= CW'(HOLD_CYC - 1);
                            state <= S_DRIVE;
                        end
                    end
                    S_DRIVE: begin
                        if (cnt == '0) begin
                            wrb_q <= 1'b1;
                            state <= S_ACKW;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_ACKW: begin
                        if (bus.ACK_I || (cnt == CW'(ACK_TIMEOUT - 1))) begin
                            oe_q  <= 1'b0;
                            cnt   <= CW'(GAP_CYC - 1);
                            state <= S_GAP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (cnt == '0) begin
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.PA_O    = pa_q;
    assign bus.PA_OE   = oe_q;
    assign bus.WRB     = wrb_q;
    assign bus.TIMEOUT = timeout_q;
    assign bus.LEVEL   = count;
    assign bus.BUSY    = (state != S_IDLE) | (count != '0);
endmodule

// File: tb/tb_upd1771c_cmd_tx.sv
// Randomised and directed bench for upd1771c_cmd_tx against a timeline model
// that expresses each transfer as CKEN-tick offsets from its write strobe.
module tb_upd1771c_cmd_tx;
    localparam int DEPTH = 4;
    localparam int HOLD  = 8;
    localparam int GAP   = 72;
    localparam int TMO   = 1024;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic CLK  = 1'b0;
    logic RESB = 1'b0;

    upd1771c_cmd_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

    upd1771c_cmd_tx #(
        .FIFO_DEPTH(DEPTH), .HOLD_CYC(HOLD), .GAP_CYC(GAP), .ACK_TIMEOUT(TMO)
    ) dut (
        .CLK (CLK),
        .RESB(RESB),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- background input generator ----------------
    int cyc      = 0;
    int ck_mode  = 0;   // 0 always, 1 every 3rd, 2 random, 3 off
    int phi_per  = 1;   // 0 off, <0 random, else period
    int phi_off  = 0;
    int ack_mode = 0;   // 0 high, 1 low, 2 random

    initial begin
        bus.CKEN  = 1'b1;
        bus.PHI2P = 1'b0;
        bus.ACK_I = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            case (ck_mode)
                0:       bus.CKEN = 1'b1;
                1:       bus.CKEN = (cyc % 3 == 0);
                2:       bus.CKEN = 1'($urandom_range(0, 1));
                default: bus.CKEN = 1'b0;
            endcase
            if (phi_per < 0)       bus.PHI2P = ($urandom_range(0, 3) == 0);
            else if (phi_per == 0) bus.PHI2P = 1'b0;
            else                   bus.PHI2P = (cyc % phi_per == phi_off);
            case (ack_mode)
                0:       bus.ACK_I = 1'b1;
                1:       bus.ACK_I = 1'b0;
                default: bus.ACK_I = ($urandom_range(0, 3) == 0);
            endcase
        end
    end

    // ---------------- reference model ----------------
    // Each transfer is a timeline of CKEN ticks k since its strobe (k=0):
    // WRB low for k<HOLD, ACK window from HOLD+1, gap of GAP ticks after the ack/timeout tick.
    logic [7:0] q[$];
    logic [7:0] m_cur   = 8'h00;
    logic [7:0] m_pa    = 8'h00;
    bit         m_oe    = 1'b0;
    bit         m_wrb   = 1'b1;
    bit         m_to    = 1'b0;
    int         m_phase = 0;    // 0 nothing in flight, 1 waiting for PHI2, 2 strobed
    int         m_k     = 0;
    int         m_ack_k = -1;
    bit         m_push, m_pop, m_set_to;

    always @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            q.delete();
            m_cur = 8'h00; m_pa = 8'h00; m_oe = 1'b0; m_wrb = 1'b1; m_to = 1'b0;
            m_phase = 0; m_k = 0; m_ack_k = -1;
        end else begin
            m_push   = bus.WR_VALID && (q.size() < DEPTH);
            m_pop    = bus.CKEN && (m_phase == 0) && (q.size() > 0);
            m_set_to = 1'b0;
            if (bus.CKEN) begin
                if (m_phase == 1 && bus.PHI2P) begin
                    m_phase = 2; m_k = 0; m_ack_k = -1;
                    m_pa = m_cur; m_oe = 1'b1; m_wrb = 1'b0;
                end else if (m_phase == 2) begin
                    m_k++;
                    if (m_k == HOLD) begin
                        m_wrb = 1'b1;
                    end else if (m_k > HOLD && m_ack_k < 0) begin
                        if (bus.ACK_I) begin
                            m_ack_k = m_k; m_oe = 1'b0;
                        end else if (m_k == HOLD + TMO) begin
                            m_ack_k = m_k; m_oe = 1'b0; m_set_to = 1'b1;
                        end
                    end else if (m_ack_k >= 0 && m_k == m_ack_k + GAP) begin
                        m_phase = 0;
                    end
                end
            end
            if (m_pop) begin
                m_cur   = q.pop_front();
                m_phase = 1;
            end
            if (m_push) q.push_back(bus.WR_DATA);
            if (bus.TO_CLR)    m_to = 1'b0;
            else if (m_set_to) m_to = 1'b1;
        end
    end

    // ---------------- per-cycle compare and event monitor ----------------
    bit         phi_at_edge = 1'b0;
    int         mon_gen = 0;
    int         last_gen = 0;
    int         n_wrb_low, n_oe, n_gap, n_ackw, n_unstable;
    bit         seen = 1'b0;
    bit         prev_wrb = 1'b1;
    logic [7:0] strobes[$];
    logic [15:0] exp_v, act_v;

    always @(posedge CLK) phi_at_edge <= bus.PHI2P && bus.CKEN;

    always @(negedge CLK) begin
        exp_v = {m_pa, m_oe, m_wrb, (q.size() < DEPTH), (m_phase != 0 || q.size() != 0),
                 m_to, LW'(q.size())};
        act_v = {bus.PA_O, bus.PA_OE, bus.WRB, bus.WR_READY, bus.BUSY, bus.TIMEOUT, bus.LEVEL};
        check("cycle{pa,oe,wrb,rdy,busy,to,lvl}", 32'(act_v), 32'(exp_v));

        if (mon_gen != last_gen) begin
            last_gen = mon_gen;
            n_wrb_low = 0; n_oe = 0; n_gap = 0; n_ackw = 0; n_unstable = 0;
            seen = 1'b0;
            strobes.delete();
        end
        if (!bus.WRB && prev_wrb) begin
            seen = 1'b1;
            strobes.push_back(bus.PA_O);
            check("align_phi2", 32'(phi_at_edge), 32'd1);
        end
        prev_wrb = bus.WRB;
        if (!bus.WRB) n_wrb_low++;
        if (bus.PA_OE) n_oe++;
        if (seen && bus.PA_OE && bus.WRB) n_ackw++;
        if (seen && bus.BUSY && !bus.PA_OE) n_gap++;
        if (seen && strobes.size() > 0 && bus.PA_O != strobes[strobes.size()-1]) n_unstable++;
    end

    // ---------------- host-side helpers ----------------
    task automatic push(input logic [7:0] d);
        int n = 0;
        bus.WR_DATA  = d;
        bus.WR_VALID = 1'b1;
        @(negedge CLK);
        while (!bus.WR_READY && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (!bus.WR_READY) bound_fail("push_wait");
        @(posedge CLK);
        #1;
        bus.WR_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK);
        while (bus.BUSY && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        if (bus.BUSY) bound_fail("idle_wait");
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_strobe();
        int n = 0;
        @(negedge CLK);
        while (bus.WRB && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        if (bus.WRB) bound_fail("strobe_wait");
    endtask

    logic [7:0] order_exp[5];

    initial begin
        bus.WR_DATA  = 8'h00;
        bus.WR_VALID = 1'b0;
        bus.TO_CLR   = 1'b0;
        order_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        repeat (3) @(posedge CLK);
        #2;
        check("rst_pa",    32'(bus.PA_O),     32'h00);
        check("rst_oe",    32'(bus.PA_OE),    32'd0);
        check("rst_wrb",   32'(bus.WRB),      32'd1);
        check("rst_ready", 32'(bus.WR_READY), 32'd1);
        check("rst_busy",  32'(bus.BUSY),     32'd0);
        check("rst_to",    32'(bus.TIMEOUT),  32'd0);
        check("rst_level", 32'(bus.LEVEL),    32'd0);
        @(negedge CLK);
        RESB = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // single byte, full-rate CKEN, PHI2 every cycle, ACK high
        mon_gen++;
        push(8'h09);
        wait_idle();
        check("single_wrb_low", 32'(n_wrb_low), 32'd8);
        check("single_oe",      32'(n_oe),      32'd9);
        check("single_ackw",    32'(n_ackw),    32'd1);
        check("single_gap",     32'(n_gap),     32'd72);
        check("single_byte",    32'(strobes.size() > 0 ? strobes[0] : 8'hxx), 32'h09);

        // alignment to a sparse PHI2 pulse train
        phi_per = 4; phi_off = 1;
        mon_gen++;
        push(8'hA5);
        repeat ($urandom_range(0, 5)) @(posedge CLK);
        #1;
        push(8'h3C);
        wait_idle();
        check("align_wrb_low", 32'(n_wrb_low), 32'd16);
        check("align_count",   32'(strobes.size()), 32'd2);

        // CKEN every third clock
        ck_mode = 1; phi_per = 1; phi_off = 0;
        mon_gen++;
        push(8'h5A);
        wait_idle();
        check("slow_wrb_low",  32'(n_wrb_low),  32'd24);
        check("slow_gap",      32'(n_gap),      32'd216);
        check("slow_oe",       32'(n_oe),       32'd27);
        check("slow_pa_stable",32'(n_unstable), 32'd0);

        // FIFO fill with the FSM frozen, then drain in order
        ck_mode = 3; phi_per = 0;
        repeat (2) @(posedge CLK);
        #1;
        mon_gen++;
        for (int i = 0; i < 4; i++) begin
            push(order_exp[i]);
            check("fill_level", 32'(bus.LEVEL), 32'(i + 1));
        end
        bus.WR_DATA  = order_exp[4];
        bus.WR_VALID = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check("full_ready", 32'(bus.WR_READY), 32'd0);
            check("full_level", 32'(bus.LEVEL),    32'd4);
        end
        ck_mode = 0;
        push(order_exp[4]);
        check("refill_level", 32'(bus.LEVEL), 32'd4);
        phi_per = 1;
        wait_idle();
        check("order_count", 32'(strobes.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            check("order_byte", 32'(i < strobes.size() ? strobes[i] : 8'hxx), 32'(order_exp[i]));

        // ACK timeout, then clear racing a second timeout
        ack_mode = 1;
        mon_gen++;
        push(8'h77);
        wait_idle();
        check("to_set",  32'(bus.TIMEOUT), 32'd1);
        check("to_ackw", 32'(n_ackw),      32'd1024);
        bus.TO_CLR = 1'b1;
        @(posedge CLK); #1;
        bus.TO_CLR = 1'b0;
        check("to_clr", 32'(bus.TIMEOUT), 32'd0);
        push(8'h78);
        wait_strobe();
        repeat (HOLD + TMO - 1) @(posedge CLK);
        #1;
        bus.TO_CLR = 1'b1;
        @(posedge CLK); #1;
        bus.TO_CLR = 1'b0;
        check("to_race_val", 32'(bus.TIMEOUT), 32'd0);
        check("to_race_gap", 32'(bus.PA_OE),   32'd0);
        wait_idle();
        ack_mode = 0;

        // reset in the middle of DRIVE
        push(8'hC3);
        push(8'hC4);
        wait_strobe();
        repeat (3) @(posedge CLK);
        #2;
        RESB = 1'b0;
        #1;
        check("mid_rst_wrb",   32'(bus.WRB),   32'd1);
        check("mid_rst_oe",    32'(bus.PA_OE), 32'd0);
        check("mid_rst_level", 32'(bus.LEVEL), 32'd0);
        check("mid_rst_busy",  32'(bus.BUSY),  32'd0);
        repeat (2) @(negedge CLK);
        RESB = 1'b1;
        @(posedge CLK); #1;
        mon_gen++;
        push(8'h96);
        wait_idle();
        check("post_rst_wrb_low", 32'(n_wrb_low), 32'd8);
        check("post_rst_byte", 32'(strobes.size() > 0 ? strobes[0] : 8'hxx), 32'h96);

        // randomised traffic
        ck_mode = 2; phi_per = -1; ack_mode = 2;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0, 1: push(8'($urandom_range(0, 255)));
                2: begin
                    repeat ($urandom_range(1, 40)) @(posedge CLK);
                    #1;
                end
                default: begin
                    bus.TO_CLR = 1'b1;
                    @(posedge CLK); #1;
                    bus.TO_CLR = 1'b0;
                end
            endcase
        end
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
